// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the RV32M multiply/divide unit.
// Holds funct3 codes, FSM state encoding and the divide special-case decode.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int DIV_ITERS = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // For divide ops f3[0] = unsigned, f3[1] = remainder.
  function automatic logic is_div_special(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    return (b == 32'd0) ||
           (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] div_special_result(input logic [2:0] f3,
                                                     input logic [31:0] a,
                                                     input logic [31:0] b);
    logic [31:0] res;
    if (b == 32'd0) res = f3[1] ? a : 32'hFFFF_FFFF;
    else            res = f3[1] ? 32'd0 : 32'h8000_0000;
    return res;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage to multiply/divide handshake bundle.
// START is level-held by the master until READY pulses (or it aborts by dropping START).
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic        START;
  logic [2:0]  M_CNT;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic [31:0] OUT;
  logic        READY;
  state_t      STATE_DBG;

  modport master (
    output START, M_CNT, RS1, RS2,
    input  OUT, READY, STATE_DBG
  );

  modport slave (
    input  START, M_CNT, RS1, RS2,
    output OUT, READY, STATE_DBG
  );
endinterface

// File: rtl/muldiv_unit_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
// The dividend is shifted out of the quotient register as quotient bits shift in.
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        last_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [32:0] trial;
  logic [31:0] diff;
  logic        ge;

  assign trial = {rem_q, quo_q[31]};
  assign ge    = trial >= {1'b0, dsr_q};
  // True difference is below the divisor, so the 32-bit wrap is exact.
  assign diff  = trial[31:0] - dsr_q;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = 32'd0;
      quo_d = dividend_i;
      dsr_d = divisor_i;
      cnt_d = 6'd0;
    end else if (step_i) begin
      rem_d = ge ? diff : trial[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q <= 32'd0;
      quo_q <= 32'd0;
      dsr_q <= 32'd0;
      cnt_q <= 6'd0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_o      = (cnt_q == 6'(DIV_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide responder: latches operands on START, returns OUT with a one-cycle READY.
// Multiply waits MUL_STAGES cycles; divide iterates in div_core, then a FIX cycle applies signs.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES    = 2,
  parameter int DIV_EARLY_OUT = 1
) (
  input logic          CLK,
  input logic          RST,
  muldiv_unit_if.slave bus
);

  state_t      state_q;
  logic [2:0]  f3_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] out_q;
  logic [1:0]  mul_cnt_q;

  // Multiply: sign/zero-extend to 64 bits; the low 64 bits of the product are exact.
  logic        a_sx, b_sx;
  logic [63:0] a64, b64, prod;
  logic [31:0] mul_res;

  assign a_sx    = (f3_q != F3_MULHU) && a_q[31];
  assign b_sx    = !f3_q[1] && b_q[31];
  assign a64     = {{32{a_sx}}, a_q};
  assign b64     = {{32{b_sx}}, b_q};
  assign prod    = a64 * b64;
  assign mul_res = (f3_q == F3_MUL) ? prod[31:0] : prod[63:32];

  logic        in_signed;
  logic [31:0] rs1_mag, rs2_mag;
  logic        div_load, div_step, div_last;
  logic [31:0] quo_mag, rem_mag;

  assign in_signed = !bus.M_CNT[0];
  assign rs1_mag   = (in_signed && bus.RS1[31]) ? (~bus.RS1 + 32'd1) : bus.RS1;
  assign rs2_mag   = (in_signed && bus.RS2[31]) ? (~bus.RS2 + 32'd1) : bus.RS2;
  assign div_load  = (state_q == ST_IDLE) && bus.START && bus.M_CNT[2];
  assign div_step  = (state_q == ST_DIV) && bus.START;

  div_core u_div_core (
    .clk_i       (CLK),
    .rst_ni      (RST),
    .load_i      (div_load),
    .step_i      (div_step),
    .dividend_i  (rs1_mag),
    .divisor_i   (rs2_mag),
    .quotient_o  (quo_mag),
    .remainder_o (rem_mag),
    .last_o      (div_last)
  );

  // Sign fixup; a zero divisor keeps the all-ones quotient unnegated.
  logic        op_signed, neg_q, neg_r;
  logic [31:0] quo_fix, rem_fix, div_res;

  assign op_signed = !f3_q[0];
  assign neg_q     = op_signed && (a_q[31] ^ b_q[31]) && (b_q != 32'd0);
  assign neg_r     = op_signed && a_q[31];
  assign quo_fix   = neg_q ? (~quo_mag + 32'd1) : quo_mag;
  assign rem_fix   = neg_r ? (~rem_mag + 32'd1) : rem_mag;
  assign div_res   = f3_q[1] ? rem_fix : quo_fix;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      f3_q      <= 3'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      out_q     <= 32'd0;
      mul_cnt_q <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            f3_q      <= bus.M_CNT;
            a_q       <= bus.RS1;
            b_q       <= bus.RS2;
            mul_cnt_q <= 2'd0;
            if (!bus.M_CNT[2]) begin
              state_q <= ST_MUL;
            end else if ((DIV_EARLY_OUT != 0) &&
                         is_div_special(bus.M_CNT, bus.RS1, bus.RS2)) begin
              out_q   <= div_special_result(bus.M_CNT, bus.RS1, bus.RS2);
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (!bus.START) begin
            state_q <= ST_IDLE;
          end else if (mul_cnt_q == 2'(MUL_STAGES - 1)) begin
            out_q   <= mul_res;
            state_q <= ST_DONE;
          end else begin
            mul_cnt_q <= mul_cnt_q + 2'd1;
          end
        end
        ST_DIV: begin
          if (!bus.START)    state_q <= ST_IDLE;
          else if (div_last) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (!bus.START) begin
            state_q <= ST_IDLE;
          end else begin
            out_q   <= div_res;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.OUT       = out_q;
  assign bus.READY     = (state_q == ST_DONE);
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with MUL_STAGES=2, DIV_EARLY_OUT=1.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if bus ();

  muldiv_unit #(.MUL_STAGES(2), .DIV_EARLY_OUT(1)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts posedges from the next one (E0) until READY is seen at a negedge.
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (bus.READY) break;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int cyc;
    @(negedge clk);
    bus.START = 1'b1;
    bus.M_CNT = f3;
    bus.RS1   = a;
    bus.RS2   = b;
    wait_ready(cyc);
    check({tag, "_lat"}, 32'(cyc - 1), 32'(lat));
    check({tag, "_out"}, bus.OUT, exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rdy_off"}, {31'd0, bus.READY}, 32'd0);
    bus.START = 1'b0;
  endtask

  initial begin
    int cyc;
    int seen;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.START = 1'b0;
    bus.M_CNT = 3'd0;
    bus.RS1   = 32'd0;
    bus.RS2   = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", bus.OUT, 32'd0);
    check("rst_ready", {31'd0, bus.READY}, 32'd0);
    check("rst_state", 32'(bus.STATE_DBG), 32'(ST_IDLE));
    rst = 1'b1;

    run_op("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);
    run_op("mulh",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2);
    run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_op("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("divu",   F3_DIVU,   32'd100,        32'd7,         32'd14,        33);
    run_op("remu",   F3_REMU,   32'd100,        32'd7,         32'd2,         33);
    run_op("div0",   F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op("rem0",   F3_REM,    32'd5,          32'd0,         32'd5,         0);
    run_op("divov",  F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("remov",  F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);

    // Abort a divide 10 cycles into DIV; OUT keeps the previous result (0).
    @(negedge clk);
    bus.START = 1'b1;
    bus.M_CNT = F3_DIVU;
    bus.RS1   = 32'd1000;
    bus.RS2   = 32'd3;
    seen = 0;
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.READY) seen++;
    end
    bus.RS1   = 32'd55;
    bus.START = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.READY) seen++;
    end
    check("abort_no_ready", 32'(seen), 32'd0);
    check("abort_state", 32'(bus.STATE_DBG), 32'(ST_IDLE));
    check("abort_out_held", bus.OUT, 32'd0);

    run_op("mul_after_abort", F3_MUL, 32'd6, 32'd7, 32'd42, 2);

    // Back-to-back with START held: exactly one IDLE cycle between results.
    @(negedge clk);
    bus.START = 1'b1;
    bus.M_CNT = F3_MUL;
    bus.RS1   = 32'd3;
    bus.RS2   = 32'd4;
    wait_ready(cyc);
    check("b2b_mul_lat", 32'(cyc - 1), 32'd2);
    check("b2b_mul_out", bus.OUT, 32'd12);
    bus.M_CNT = F3_DIVU;
    bus.RS1   = 32'd9;
    bus.RS2   = 32'd2;
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_state", 32'(bus.STATE_DBG), 32'(ST_IDLE));
    check("b2b_idle_ready", {31'd0, bus.READY}, 32'd0);
    check("b2b_out_held", bus.OUT, 32'd12);
    wait_ready(cyc);
    check("b2b_div_lat", 32'(cyc - 1), 32'd33);
    check("b2b_div_out", bus.OUT, 32'd4);
    @(negedge clk);
    bus.START = 1'b0;

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.START = 1'b1;
    bus.M_CNT = F3_DIVU;
    bus.RS1   = 32'd100;
    bus.RS2   = 32'd7;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_state", 32'(bus.STATE_DBG), 32'(ST_IDLE));
    check("midrst_ready", {31'd0, bus.READY}, 32'd0);
    check("midrst_out", bus.OUT, 32'd0);
    bus.START = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Responder side of the execute stage's multiply/divide handshake: implements the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- The execute stage holds START high and stalls while READY is low; this block captures operands, computes, and returns a result with a one-cycle READY pulse.
- Multiply uses a short register pipeline. Divide uses an iterative radix-2 restoring core with single-cycle early-out for special cases.

Parameters:
MUL_STAGES, 2, multiply pipeline depth in cycles (legal 1..4)
DIV_EARLY_OUT, 1, 1 = divide-by-zero and signed overflow complete without iterating

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-low reset (low at an edge = reset)
START  input  1  op request; level-held by the execute stage for the whole op; already masked by flush upstream
M_CNT  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
RS1  input  32  rs1 operand (multiplicand / dividend)
RS2  input  32  rs2 operand (multiplier / divisor)
OUT  output  32  result, registered; valid while READY=1, then held until the next result
READY  output  1  result-valid pulse, exactly one cycle per completed op

Behaviour:
- Reset: state IDLE; OUT=0; READY=0; iteration counter=0; operand/quotient/remainder registers=0. Reset mid-op discards the op with no READY.
- States: IDLE, MUL, DIV, FIX, DONE. READY = (state==DONE), decoded from state, glitch-free.
- IDLE: at edge E0 with START=1, latch RS1, RS2, M_CNT.
  - M_CNT[2]=0 -> MUL.
  - DIV_EARLY_OUT and the divide is a special case -> DONE with OUT loaded.
  - Otherwise -> DIV.
- MUL: 64-bit product of the sign/zero-extended operands.
  - Signedness: MUL/MULH signed x signed; MULHSU signed RS1 x unsigned RS2; MULHU unsigned x unsigned.
  - OUT = product[31:0] for MUL, product[63:32] otherwise.
  - State goes to DONE at edge E0+MUL_STAGES.
- DIV: operate on magnitudes (signed ops take absolute values; |-2^31| is handled as unsigned 0x80000000).
  - One quotient bit per cycle, MSB first, 32 iterations at E1..E32, then -> FIX.
- FIX (one cycle):
  - Quotient negated if signs differ (signed ops only).
  - Remainder takes the dividend sign.
  - OUT = quotient (DIV/DIVU) or remainder (REM/REMU).
  - -> DONE at E33.
- Special cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = RS1.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - With DIV_EARLY_OUT=0 these go through the iterative path and produce the same values.
- DONE: READY=1 for this cycle only. Next edge -> IDLE regardless of START; a still-high START in IDLE is treated as a new instruction.
  - Back-to-back ops therefore always see one IDLE cycle between them.
- Latency (READY high in the cycle after the listed edge):
  - multiply: E0+MUL_STAGES
  - normal divide: E0+33
  - early-out divide: E0
- Abort: START=0 at any edge while in MUL, DIV or FIX -> IDLE. No READY; OUT is unchanged. Operand changes while busy are ignored (operands are latched).
- START=0 in IDLE: stay idle, registers hold.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU)
  - state encoding (ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE)
  - DIV_ITERS=32
- One sub-module, div_core: restoring divider holding the remainder/quotient shift registers and the 6-bit iteration counter.
  - Inputs: load, step, magnitudes.
  - Outputs: unsigned quotient and remainder.
  - Sign fixup and FSM stay in muldiv_unit.

Test Plan:
- MUL 7 x 0xFFFFFFFD (MUL_STAGES=2) -> OUT=0xFFFFFFEB, READY one cycle after edge E0+2, then READY=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; DIVU 100/7 -> 14 and REMU -> 2; READY after E0+33.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each READY after E0 (DIV_EARLY_OUT=1).
- DIVU 1000/3 with START dropped 10 cycles into DIV -> no READY and OUT unchanged. A following MUL 6x7 -> 42 with correct latency. RST=0 during a divide -> IDLE, READY=0, OUT=0.
- START held high across two consecutive ops (MUL 3x4 then DIVU 9/2) -> READY pulses with OUT=12, then OUT=4, with exactly one IDLE cycle between them.
